hilo_muldiv: RTL and testbench

//  Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It sits in EX and drives the hi/lo

---
 rtl/hilo_muldiv.sv | 139 +++++++++++++
 tb/tb_hilo_muldiv.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the hi/lo register write ports.
// One shift-add or shift-subtract step per cycle; signs are handled on magnitudes and fixed up at the end.
module hilo_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic             hi_we,
  output logic [WIDTH-1:0] hi_data,
  output logic             lo_we,
  output logic [WIDTH-1:0] lo_data
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DZERO, S_DONE} state_t;
  state_t state, state_next;

  // acc is {partial product, multiplier} for MUL and {remainder, quotient/dividend} for DIV
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [CW-1:0]      cnt;
  logic               sign_a, sign_b;

  logic               is_signed, in_sign_a, in_sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step, mul_res;
  logic [WIDTH-1:0]   quo, rem, raw_a;
  logic               neg;

  always_comb begin
    is_signed = ~op[0];
    in_sign_a = is_signed & src_a[WIDTH-1];
    in_sign_b = is_signed & src_b[WIDTH-1];
    abs_a     = in_sign_a ? -src_a : src_a;
    abs_b     = in_sign_b ? -src_b : src_b;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_step  = {mul_sum, acc[WIDTH-1:1]};

    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    div_step  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    neg     = sign_a ^ sign_b;
    mul_res = neg ? -mul_step : mul_step;
    quo     = neg ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
    rem     = sign_a ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
    // Re-negating the stored magnitude restores the raw dividend for the divide-by-zero result
    raw_a   = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !flush) begin
          if (op[1] && src_b == '0) state_next = S_DZERO;
          else if (op[1])           state_next = S_DIV;
          else                      state_next = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)             state_next = S_IDLE;
        else if (cnt == LAST)  state_next = S_DONE;
      end
      S_DZERO: state_next = flush ? S_IDLE : S_DONE;
      S_DONE: begin
        state_next = S_IDLE;
        done       = ~flush;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign hi_we     = done;
  assign lo_we     = done;
  assign busy      = (state != S_IDLE);
  assign stall_req = start | busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      opb     <= '0;
      cnt     <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      hi_data <= '0;
      lo_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !flush) begin
            acc    <= (2*WIDTH)'(abs_a);
            opb    <= abs_b;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            cnt    <= '0;
          end
        end
        S_MUL: begin
          acc <= mul_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST && !flush) {hi_data, lo_data} <= mul_res;
        end
        S_DIV: begin
          acc <= div_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST && !flush) {hi_data, lo_data} <= {rem, quo};
        end
        S_DZERO: begin
          if (!flush) begin
            hi_data <= raw_a;
            lo_data <= '1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed and random checks of hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start, flush;
  logic [1:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          busy, stall_req, done, hi_we, lo_we;
  logic [W-1:0]  hi_data, lo_data;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .stall_req(stall_req), .done(done), .hi_we(hi_we),
    .hi_data(hi_data), .lo_we(lo_we), .lo_data(lo_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference result as {hi, lo}, straight from the arithmetic definitions
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // mode 0: normal, 1: start held with changing operands, 2: flush in the DONE cycle
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int mode);
    logic [63:0] exp;
    int lat, n;
    bit got, busy_ok, early_we;
    exp = model(o, a, b);
    lat = (o[1] && b == 0) ? 2 : W + 1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check_bit("stall_at_T", stall_req, 1'b1);
    check_bit("idle_at_T", busy, 1'b0);
    n = 0; got = 0; busy_ok = 1; early_we = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (mode == 1) begin
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      #1;
      if (!busy || !stall_req) busy_ok = 0;
      if (done) got = 1;
      else if (hi_we || lo_we) early_we = 1;
    end
    check_bit("done_seen", got, 1'b1);
    check_val("latency", 64'(n), 64'(lat));
    check_bit("busy_stall_held", busy_ok, 1'b1);
    check_bit("no_early_write", early_we, 1'b0);
    if (mode == 2) begin
      flush = 1'b1;
      #1;
      check_bit("flush_done_suppress", done | hi_we | lo_we, 1'b0);
    end else begin
      check_bit("hi_we_pulse", hi_we, 1'b1);
      check_bit("lo_we_pulse", lo_we, 1'b1);
    end
    check_val("result", {hi_data, lo_data}, exp);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check_bit("strobe_drop", done | hi_we | lo_we, 1'b0);
    check_bit("busy_drop", busy, 1'b0);
    check_val("result_hold", {hi_data, lo_data}, exp);
  endtask

  task automatic abort_test(input bit use_rst);
    logic [63:0] prev;
    bit we_seen;
    prev = {hi_data, lo_data};
    op = 2'b00; src_a = $urandom; src_b = $urandom; start = 1'b1;
    we_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) begin
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
      end
      if (k == 11) begin
        rst = 1'b0; flush = 1'b0;
      end
      #1;
      if (hi_we || lo_we || done) we_seen = 1;
      if (k == 10) check_bit("busy_before_abort", busy, 1'b1);
      if (k == 11) begin
        check_bit("abort_idle", busy | stall_req | done, 1'b0);
        check_val("abort_data", {hi_data, lo_data}, use_rst ? 64'd0 : prev);
      end
    end
    check_bit("abort_no_write", we_seen, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_strobes", done | hi_we | lo_we | stall_req, 1'b0);
    check_val("rst_data", {hi_data, lo_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(2'b01, 32'd7, 32'd6, 0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'd3, 0);
    check_val("mult_neg1x3", {hi_data, lo_data}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd3, 0);
    check_val("multu_ffx3", {hi_data, lo_data}, 64'h0000_0002_FFFF_FFFD);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check_val("div_m7_2", {hi_data, lo_data}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b11, 32'd100, 32'd7, 0);
    check_val("divu_100_7", {hi_data, lo_data}, {32'd2, 32'd14});
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_val("div_overflow", {hi_data, lo_data}, {32'd0, 32'h8000_0000});
    do_op(2'b11, 32'd5, 32'd0, 0);
    check_val("divu_by_zero", {hi_data, lo_data}, {32'd5, 32'hFFFF_FFFF});
    do_op(2'b10, 32'h8000_0000, 32'd0, 0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);

    abort_test(1'b0);
    abort_test(1'b1);

    // flush and start together in IDLE: start must be dropped
    start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check_bit("idle_flush_priority", busy, 1'b0);

    do_op(2'b00, 32'hFFFF_FF00, 32'd1234, 1);
    do_op(2'b11, 32'd77, 32'd5, 2);
    do_op(2'b10, 32'h8765_4321, 32'd333, 0);

    for (int i = 0; i < 24; i++) begin
      logic [1:0] o;
      logic [W-1:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(o, a, b, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
